// File: rtl/arcade_input_mux.sv
// arcade_input_mux: player-input front end for arcade cores.
// Merges PS/2 keyboard keys and per-player HPS joysticks into registered,
// active-low player controls. Stretches coin pulses to at least COIN_MIN
// clocks and captures the DIP-switch bank from the ioctl stream (index 254).
//
// Ports:
//   clk_49m      system clock
//   reset        synchronous, active-high
//   ps2_key      [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   joystick     player p in [16p+15:16p]: 0 R, 1 L, 2 D, 3 U, 4.. buttons,
//                4+BUTTONS start, 5+BUTTONS coin
//   ioctl_*      HPS download stream; DIP bytes arrive on index 254
//   autofire_en  per-player autofire request on button 0
//   joy_n        {R,L,D,U} per player, active-low
//   btn_n        fire buttons, active-low
//   start_n      start per player, active-low
//   coin_n       stretched coin per player, active-low
//   service_n    service key, active-low
//   dip_sw       inverted stored DIP bytes, byte k in [8k+7:8k]
//
// Optional feature: define ARCADE_AUTOFIRE_EN to build per-player autofire
// on button 0; without it autofire_en is ignored.
module arcade_input_mux #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 3,
  parameter int unsigned DIP_BYTES    = 8,
  parameter logic [15:0] COIN_MIN     = 16'd49152,
  parameter logic [19:0] AUTOFIRE_DIV = 20'd409600
) (
  input  logic                         clk_49m,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [PLAYERS*16-1:0]        joystick,
  input  logic                         ioctl_wr,
  input  logic [7:0]                   ioctl_index,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  input  logic [PLAYERS-1:0]           autofire_en,
  output logic [PLAYERS*4-1:0]         joy_n,
  output logic [PLAYERS*BUTTONS-1:0]   btn_n,
  output logic [PLAYERS-1:0]           start_n,
  output logic [PLAYERS-1:0]           coin_n,
  output logic                         service_n,
  output logic [DIP_BYTES*8-1:0]       dip_sw
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned AF_W  = 20;

  // ---------------------------------------------------------------
  // Keyboard decode
  // ---------------------------------------------------------------
  logic       toggle_q;
  logic       key_evt;
  logic [1:0] key_idx;
  logic       hit_dir, hit_btn, hit_start, hit_coin, hit_svc;

  assign key_evt = ps2_key[10] ^ toggle_q;

  // Scancode to key group and index within the group; extended bit ignored
  always_comb begin
    hit_dir   = 1'b0;
    hit_btn   = 1'b0;
    hit_start = 1'b0;
    hit_coin  = 1'b0;
    hit_svc   = 1'b0;
    key_idx   = 2'd0;
    case (ps2_key[7:0])
      8'h75: begin hit_dir   = 1'b1; key_idx = 2'd0; end
      8'h72: begin hit_dir   = 1'b1; key_idx = 2'd1; end
      8'h6B: begin hit_dir   = 1'b1; key_idx = 2'd2; end
      8'h74: begin hit_dir   = 1'b1; key_idx = 2'd3; end
      8'h14: begin hit_btn   = 1'b1; key_idx = 2'd0; end
      8'h11: begin hit_btn   = 1'b1; key_idx = 2'd1; end
      8'h29: begin hit_btn   = 1'b1; key_idx = 2'd2; end
      8'h12: begin hit_btn   = 1'b1; key_idx = 2'd3; end
      8'h16: begin hit_start = 1'b1; key_idx = 2'd0; end
      8'h1E: begin hit_start = 1'b1; key_idx = 2'd1; end
      8'h26: begin hit_start = 1'b1; key_idx = 2'd2; end
      8'h25: begin hit_start = 1'b1; key_idx = 2'd3; end
      8'h2E: begin hit_coin  = 1'b1; key_idx = 2'd0; end
      8'h36: begin hit_coin  = 1'b1; key_idx = 2'd1; end
      8'h3D: begin hit_coin  = 1'b1; key_idx = 2'd2; end
      8'h3E: begin hit_coin  = 1'b1; key_idx = 2'd3; end
      8'h46: hit_svc = 1'b1;
      default: ;
    endcase
  end

  // Key latches; only indices that exist for this configuration are kept
  logic [3:0]         key_dir;   // {R,L,D,U}
  logic [BUTTONS-1:0] key_btn;
  logic [PLAYERS-1:0] key_start;
  logic [PLAYERS-1:0] key_coin;
  logic               key_svc;

  always_ff @(posedge clk_49m) begin
    // Toggle copy tracks the input in reset too, so no event follows reset
    toggle_q <= ps2_key[10];
    if (reset) begin
      key_dir   <= '0;
      key_btn   <= '0;
      key_start <= '0;
      key_coin  <= '0;
      key_svc   <= 1'b0;
    end else if (key_evt) begin
      if (hit_dir) key_dir[key_idx] <= ps2_key[9];
      for (int b = 0; b < BUTTONS; b++)
        if (hit_btn && key_idx == 2'(b)) key_btn[b] <= ps2_key[9];
      for (int p = 0; p < PLAYERS; p++) begin
        if (hit_start && key_idx == 2'(p)) key_start[p] <= ps2_key[9];
        if (hit_coin  && key_idx == 2'(p)) key_coin[p]  <= ps2_key[9];
      end
      if (hit_svc) key_svc <= ps2_key[9];
    end
  end

  // ---------------------------------------------------------------
  // Keyboard / joystick merge (active-high)
  // ---------------------------------------------------------------
  logic [PLAYERS*4-1:0]       dir_m;
  logic [PLAYERS*BUTTONS-1:0] btn_m;
  logic [PLAYERS-1:0]         start_m;
  logic [PLAYERS-1:0]         coin_m;

  // Arrows and buttons from the keyboard go to player 0 only
  always_comb begin
    dir_m   = '0;
    btn_m   = '0;
    start_m = '0;
    coin_m  = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      dir_m[4*p+0] = joystick[16*p+3];
      dir_m[4*p+1] = joystick[16*p+2];
      dir_m[4*p+2] = joystick[16*p+1];
      dir_m[4*p+3] = joystick[16*p+0];
      for (int b = 0; b < BUTTONS; b++)
        btn_m[p*BUTTONS+b] = joystick[16*p+4+b];
      start_m[p] = joystick[16*p+4+BUTTONS] | key_start[p];
      coin_m[p]  = joystick[16*p+5+BUTTONS] | key_coin[p];
    end
    dir_m[3:0]         = dir_m[3:0] | key_dir;
    btn_m[BUTTONS-1:0] = btn_m[BUTTONS-1:0] | key_btn;
  end

  // ---------------------------------------------------------------
  // Autofire on button 0
  // ---------------------------------------------------------------
  logic [PLAYERS*BUTTONS-1:0] btn_eff;

`ifdef ARCADE_AUTOFIRE_EN
  logic [AF_W-1:0]    af_cnt [PLAYERS];
  logic [PLAYERS-1:0] af_phase;   // 1 = forced-release half period
  logic [PLAYERS-1:0] af_hold;

  always_comb begin
    af_hold = '0;
    btn_eff = btn_m;
    for (int p = 0; p < PLAYERS; p++) begin
      af_hold[p] = btn_m[p*BUTTONS] & autofire_en[p];
      btn_eff[p*BUTTONS] = btn_m[p*BUTTONS] & ~(af_hold[p] & af_phase[p]);
    end
  end

  // Phase counter idles at zero whenever not held, so each press starts pressed
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      af_phase <= '0;
      for (int p = 0; p < PLAYERS; p++) af_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (!af_hold[p]) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= 1'b0;
        end else if (af_cnt[p] == AUTOFIRE_DIV - AF_W'(1)) begin
          af_cnt[p]   <= '0;
          af_phase[p] <= ~af_phase[p];
        end else begin
          af_cnt[p] <= af_cnt[p] + AF_W'(1);
        end
      end
    end
  end
`else
  assign btn_eff = btn_m;
`endif

  // ---------------------------------------------------------------
  // Coin stretcher
  // ---------------------------------------------------------------
  logic [PLAYERS-1:0] coin_q, coin_prev;
  logic [CNT_W-1:0]   coin_cnt     [PLAYERS];
  logic [CNT_W-1:0]   coin_cnt_nxt [PLAYERS];
  logic [PLAYERS-1:0] coin_busy;

  // Output uses the next count so the low time is exactly COIN_MIN clocks
  always_comb begin
    coin_busy = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (coin_q[p] && !coin_prev[p])
        coin_cnt_nxt[p] = COIN_MIN;
      else if (coin_cnt[p] != '0)
        coin_cnt_nxt[p] = coin_cnt[p] - CNT_W'(1);
      else
        coin_cnt_nxt[p] = '0;
      coin_busy[p] = coin_q[p] | (coin_cnt_nxt[p] != '0);
    end
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      coin_q    <= '0;
      coin_prev <= '0;
      for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= '0;
    end else begin
      coin_q    <= coin_m;
      coin_prev <= coin_q;
      for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= coin_cnt_nxt[p];
    end
  end

  // ---------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      joy_n     <= '1;
      btn_n     <= '1;
      start_n   <= '1;
      coin_n    <= '1;
      service_n <= 1'b1;
    end else begin
      joy_n     <= ~dir_m;
      btn_n     <= ~btn_eff;
      start_n   <= ~start_m;
      coin_n    <= ~coin_busy;
      service_n <= ~key_svc;
    end
  end

  // ---------------------------------------------------------------
  // DIP bank: stored inverted, powers up all-ones, untouched by reset
  // ---------------------------------------------------------------
  logic [DIP_BYTES*8-1:0] dip_inv = '1;
  logic                   dip_wr;

  assign dip_wr = ioctl_wr && (ioctl_index == 8'd254) &&
                  (ioctl_addr < 25'(DIP_BYTES));

  always_ff @(posedge clk_49m) begin
    for (int k = 0; k < DIP_BYTES; k++)
      if (dip_wr && ioctl_addr == 25'(k)) dip_inv[8*k +: 8] <= ~ioctl_dout;
  end

  assign dip_sw = dip_inv;

  // Inputs that carry no function in this configuration
  logic unused_sig;
  assign unused_sig = ^{ps2_key[8], joystick, autofire_en};

endmodule

// File: tb/tb_arcade_input_mux.sv
// Directed bench for arcade_input_mux (PLAYERS=2, BUTTONS=3, DIP_BYTES=8,
// COIN_MIN=10, AUTOFIRE_DIV=4). Expected values are queued with a due cycle
// when stimulus is applied and compared when that cycle is reached.
module tb_arcade_input_mux;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [1:0]  autofire_en;
  logic [7:0]  joy_n;
  logic [5:0]  btn_n;
  logic [1:0]  start_n;
  logic [1:0]  coin_n;
  logic        service_n;
  logic [63:0] dip_sw;

  always #5 clk_49m = ~clk_49m;

  arcade_input_mux #(
    .PLAYERS(2), .BUTTONS(3), .DIP_BYTES(8),
    .COIN_MIN(16'd10), .AUTOFIRE_DIV(20'd4)
  ) dut (
    .clk_49m(clk_49m), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .autofire_en(autofire_en), .joy_n(joy_n),
    .btn_n(btn_n), .start_n(start_n), .coin_n(coin_n), .service_n(service_n),
    .dip_sw(dip_sw)
  );

  localparam int S_JOY = 0, S_BTN = 1, S_START = 2, S_COIN = 3, S_SVC = 4, S_DIP = 5;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       tag;
  } chk_t;

  chk_t        sb[$];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  logic        tgl   = 1'b0;
  logic [63:0] dip_model;

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S_JOY:   return 64'(joy_n);
      S_BTN:   return 64'(btn_n);
      S_START: return 64'(start_n);
      S_COIN:  return 64'(coin_n);
      S_SVC:   return 64'(service_n);
      default: return dip_sw;
    endcase
  endfunction

  task automatic compare(input int sel, input logic [63:0] e, input string tag);
    logic [63:0] o;
    o = obs(sel);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic expect_in(input int lat, input int sel, input logic [63:0] e,
                           input string tag);
    chk_t c;
    c.due = cyc + lat;
    c.sel = sel;
    c.exp = e;
    c.tag = tag;
    sb.push_back(c);
  endtask

  task automatic expect_idle(input int lat, input string tag);
    expect_in(lat, S_JOY,   64'hFF, {tag, "_joy"});
    expect_in(lat, S_BTN,   64'h3F, {tag, "_btn"});
    expect_in(lat, S_START, 64'h3,  {tag, "_start"});
    expect_in(lat, S_COIN,  64'h3,  {tag, "_coin"});
    expect_in(lat, S_SVC,   64'h1,  {tag, "_svc"});
  endtask

  // Advance n clocks; check due entries on the falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_49m);
      @(negedge clk_49m);
      cyc++;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].due == cyc) begin
          compare(sb[j].sel, sb[j].exp, sb[j].tag);
          sb.delete(j);
        end
      end
    end
  endtask

  task automatic kb(input logic pr, input logic ext, input logic [7:0] code);
    tgl = ~tgl;
    ps2_key = {tgl, pr, ext, code};
  endtask

  task automatic dip_write(input logic [7:0] idx, input logic [24:0] addr,
                           input logic [7:0] data);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
  endtask

  initial begin
    reset       = 1'b1;
    ps2_key     = '0;
    joystick    = '0;
    ioctl_wr    = 1'b0;
    ioctl_index = '0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    autofire_en = '0;
    dip_model   = '1;

    #1;
    compare(S_DIP, dip_model, "dip_powerup");
    @(negedge clk_49m);

    // Reset state
    expect_idle(2, "reset");
    step(2);
    reset = 1'b0;
    expect_idle(1, "post_reset");
    step(1);

    // Keyboard up arrow (extended set, ignored): 2-clock latency, player 0 only
    kb(1'b1, 1'b1, 8'h75);
    expect_in(1, S_JOY, 64'hFF, "kb_up_lat1");
    expect_in(2, S_JOY, 64'hFE, "kb_up_press");
    step(2);
    kb(1'b0, 1'b1, 8'h75);
    expect_in(1, S_JOY, 64'hFE, "kb_up_rel_lat1");
    expect_in(2, S_JOY, 64'hFF, "kb_up_release");
    step(2);

    // Button 2, service, start 2 via keyboard
    kb(1'b1, 1'b0, 8'h29);
    expect_in(2, S_BTN, 64'h3B, "kb_btn2");
    step(2);
    kb(1'b1, 1'b0, 8'h46);
    expect_in(2, S_SVC, 64'h0, "kb_service");
    step(2);
    kb(1'b1, 1'b0, 8'h1E);
    expect_in(2, S_START, 64'h1, "kb_start2");
    step(2);
    // Unlisted code and out-of-range indices are ignored
    kb(1'b1, 1'b0, 8'h99);
    expect_in(2, S_JOY, 64'hFF, "kb_unlisted_joy");
    expect_in(2, S_BTN, 64'h3B, "kb_unlisted_btn");
    step(2);
    kb(1'b1, 1'b0, 8'h12);
    expect_in(2, S_BTN, 64'h3B, "kb_btn3_ignored");
    step(2);
    kb(1'b1, 1'b0, 8'h26);
    expect_in(2, S_START, 64'h1, "kb_start3_ignored");
    step(2);
    kb(1'b0, 1'b0, 8'h29); step(1);
    kb(1'b0, 1'b0, 8'h46); step(1);
    kb(1'b0, 1'b0, 8'h1E);
    expect_in(2, S_BTN,   64'h3F, "kb_rel_btn");
    expect_in(2, S_SVC,   64'h1,  "kb_rel_svc");
    expect_in(2, S_START, 64'h3,  "kb_rel_start");
    step(2);

    // Joystick passthrough: player 1 up, 1-clock latency
    joystick[19] = 1'b1;
    expect_in(1, S_JOY, 64'hEF, "joy_p1_up");
    step(1);
    kb(1'b1, 1'b0, 8'h75);
    expect_in(2, S_JOY, 64'hEE, "joy_p1_up_kb_up");
    step(2);
    joystick[19] = 1'b0;
    expect_in(1, S_JOY, 64'hFE, "kb_up_not_p1");
    step(1);
    kb(1'b0, 1'b0, 8'h75);
    expect_in(2, S_JOY, 64'hFF, "kb_up_release2");
    step(2);

    // Joystick down held, then keyboard down press with joystick release
    joystick[2] = 1'b1;
    expect_in(1, S_JOY, 64'hFD, "joy_p0_down");
    step(1);
    joystick[2] = 1'b0;
    kb(1'b1, 1'b0, 8'h72);
    expect_in(2, S_JOY, 64'hFD, "kb_press_joy_release");
    step(2);
    kb(1'b0, 1'b0, 8'h72);
    expect_in(2, S_JOY, 64'hFF, "kb_down_release");
    step(2);

    // Joystick buttons and start
    joystick = (32'd1 << 21) | (32'd1 << 7);
    expect_in(1, S_BTN,   64'h2F, "joy_p1_btn1");
    expect_in(1, S_START, 64'h2,  "joy_p0_start");
    step(1);
    joystick = '0;
    expect_in(1, S_BTN,   64'h3F, "joy_btn_rel");
    expect_in(1, S_START, 64'h3,  "joy_start_rel");
    step(1);

    // Autofire on player 0 button 0
    joystick[4] = 1'b1;
    autofire_en = 2'b01;
    for (int k = 1; k <= 12; k++) begin
`ifdef ARCADE_AUTOFIRE_EN
      expect_in(k, S_BTN, ((((k - 1) / 4) % 2) == 1) ? 64'h3F : 64'h3E, "autofire");
`else
      expect_in(k, S_BTN, 64'h3E, "btn0_steady");
`endif
    end
    step(12);
    joystick[4] = 1'b0;
    expect_in(1, S_BTN, 64'h3F, "autofire_release");
    step(1);
    autofire_en = 2'b00;

    // Coin: single 1-clock pulse -> low for exactly 10 clocks
    for (int k = 1; k <= 13; k++)
      expect_in(k, S_COIN, (k >= 2 && k <= 11) ? 64'h2 : 64'h3, "coin_single");
    joystick[8] = 1'b1;
    step(1);
    joystick[8] = 1'b0;
    step(12);

    // Coin: second edge while counting reloads to a fresh 10 clocks
    for (int k = 1; k <= 20; k++)
      expect_in(k, S_COIN, (k >= 2 && k <= 18) ? 64'h2 : 64'h3, "coin_retrigger");
    joystick[8] = 1'b1;
    step(1);
    joystick[8] = 1'b0;
    step(6);
    joystick[8] = 1'b1;
    step(1);
    joystick[8] = 1'b0;
    step(12);

    // DIP capture
    dip_write(8'd254, 25'd1, 8'h5A);
    dip_model[15:8] = 8'hA5;
    expect_in(1, S_DIP, dip_model, "dip_addr1");
    step(1);
    dip_write(8'd254, 25'd8, 8'h33);
    expect_in(1, S_DIP, dip_model, "dip_addr8_discard");
    step(1);
    dip_write(8'd0, 25'd2, 8'h77);
    expect_in(1, S_DIP, dip_model, "dip_index0_discard");
    step(1);
    dip_write(8'd254, 25'd7, 8'h81);
    dip_model[63:56] = 8'h7E;
    expect_in(1, S_DIP, dip_model, "dip_addr7");
    step(1);
    ioctl_wr = 1'b0;
    step(1);

    // Reset mid-coin with a simultaneous DIP write
    for (int k = 1; k <= 5; k++)
      expect_in(k, S_COIN, (k >= 2) ? 64'h2 : 64'h3, "coin_before_reset");
    joystick[8] = 1'b1;
    step(1);
    joystick[8] = 1'b0;
    step(4);
    reset = 1'b1;
    dip_write(8'd254, 25'd3, 8'h0F);
    dip_model[31:24] = 8'hF0;
    expect_in(1, S_COIN, 64'h3, "coin_reset_high");
    expect_in(1, S_DIP, dip_model, "dip_write_during_reset");
    step(1);
    ioctl_wr = 1'b0;
    expect_in(1, S_DIP, dip_model, "dip_kept_in_reset");
    step(1);
    reset = 1'b0;
    expect_in(1, S_COIN, 64'h3, "coin_after_reset1");
    expect_in(2, S_COIN, 64'h3, "coin_after_reset2");
    step(2);

    // Reset glitch: toggle changes during reset, no event afterwards
    reset = 1'b1;
    tgl = ~tgl;
    ps2_key = {tgl, 1'b1, 1'b0, 8'h75};
    step(2);
    reset = 1'b0;
    expect_idle(1, "glitch1");
    expect_idle(2, "glitch2");
    expect_idle(3, "glitch3");
    step(3);

    // Drain anything still queued, with a bound
    for (int g = 0; g < 64 && sb.size() > 0; g++) step(1);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
